pass_seq_ctrl: RTL and testbench
================================

# pass_seq_ctrl

Sequencing controller for the keypad password lock. Watches the raw 16-button keypad and accepts one key per press/release. It drives the enable of the encoder/shift-register datapath and the load enable of the stored-password register, then samples the equality comparator after the last digit. It also handles unlock timing, failed-attempt counting, alarm lockout and re-programming of the password.

## Interface
Parameters:
- DIGITS, 4: keys per code entry (1..8); the shift datapath holds 4 bits per digit.
- MAX_TRIES, 3: consecutive failed checks that trigger lockout (1..15).
- OPEN_CYCLES, 500: clock cycles UNLOCK stays high after a match (≥1).
- LOCK_CYCLES, 1000: clock cycles ALARM/lockout lasts (≥1).

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- BUTTONS  in  16  raw keypad levels, one bit per key. Already synchronized upstream.
- PROG_REQ  in  1  level request to program a new password.
- EQUAL  in  1  comparator result (entered code == stored code), combinational.
- SHIFT_EN  out  1  one-cycle pulse; enables the encoder/shift datapath for the accepted key.
- REG_LOAD  out  1  one-cycle pulse; loads the password register from the shift output.
- UNLOCK  out  1  lock-open indication.
- ALARM  out  1  lockout indication.
- BUSY  out  1  high in every state except IDLE.
- DIGIT_CNT  out  4  keys accepted in the current entry.
- TRIES  out  4  consecutive failed checks.

## Operation
- Key acceptance: a key is accepted when BUTTONS is exactly one-hot in the current cycle and was all-zero in the previous sampled cycle.
  - Multi-bit patterns are ignored.
  - A held key is accepted once. It must return to zero before the next key is accepted.
  - Keys are accepted only in IDLE, ENTRY and PROG_ENTRY.
  - The release tracker runs in every state, so a key held across a state change is never accepted.
- States:
  - IDLE: accepted key → SHIFT_EN, DIGIT_CNT=1, go to ENTRY. With DIGITS=1, go directly to CHECK.
  - ENTRY: each accepted key pulses SHIFT_EN and increments DIGIT_CNT. The DIGITS-th key goes to CHECK.
  - CHECK: one cycle, with the datapath already updated. Sample EQUAL.
    - EQUAL=1: TRIES←0, go to OPEN.
    - EQUAL=0: TRIES+1. If the new value equals MAX_TRIES, go to LOCKOUT; otherwise go to IDLE.
    - DIGIT_CNT←0 on exit.
  - OPEN: UNLOCK=1 for OPEN_CYCLES cycles, then IDLE.
    - PROG_REQ=1 in any OPEN cycle goes to PROG_ENTRY on the next edge and UNLOCK drops.
  - PROG_ENTRY: accepted keys pulse SHIFT_EN and increment DIGIT_CNT. The DIGITS-th key goes to PROG_LOAD.
  - PROG_LOAD: one cycle; REG_LOAD=1, DIGIT_CNT←0, then IDLE.
  - LOCKOUT: ALARM=1 for LOCK_CYCLES cycles; all keys and PROG_REQ are ignored. Then TRIES←0 and go to IDLE.
- PROG_REQ outside OPEN is ignored.
- TRIES saturates at MAX_TRIES and never wraps.
- A single down-counter, wide enough for max(OPEN_CYCLES, LOCK_CYCLES), times both OPEN and LOCKOUT. It loads on state entry.

## Timing
- Reset (RST=0, asynchronous): state IDLE, SHIFT_EN=0, REG_LOAD=0, UNLOCK=0, ALARM=0, BUSY=0, DIGIT_CNT=0, TRIES=0, previous-buttons register=0.
- All outputs are registered.
- Key accept: a valid edge seen at rising edge N gives SHIFT_EN high during cycle N+1 only. DIGIT_CNT updates at the same edge.
- Final digit: last SHIFT_EN in cycle N+1, CHECK in cycle N+2, EQUAL sampled at the end of N+2. UNLOCK or ALARM rises in cycle N+3.
- OPEN lasts exactly OPEN_CYCLES cycles and LOCKOUT exactly LOCK_CYCLES cycles. BUSY is high throughout both.
- REG_LOAD is high exactly one cycle, two cycles after the final programming key is sampled.
- Reset mid-operation aborts any state immediately: no SHIFT_EN or REG_LOAD completes, and TRIES is cleared.
- The datapath registers share RST and are cleared by the same reset.

## Test plan
Parameters for all scenarios: DIGITS=4, MAX_TRIES=3, OPEN_CYCLES=10, LOCK_CYCLES=20.
- Reset: after RST low, all outputs are 0. Then enter keys 1,2,3,4 with EQUAL forced 1 in CHECK → exactly 4 SHIFT_EN pulses, DIGIT_CNT 1..4, UNLOCK high for exactly 10 cycles, TRIES=0.
- Press handling:
  - Hold key 5 for 8 cycles → one SHIFT_EN only.
  - BUTTONS=16'h0003 → no pulse.
  - Key held from OPEN into IDLE → not accepted until released.
- Wrong code: three 4-key entries with EQUAL=0 → TRIES 1, 2, 3. After the third, ALARM high for exactly 20 cycles with keys ignored (no SHIFT_EN). Then TRIES=0 and IDLE.
- Programming:
  - In OPEN, raise PROG_REQ → UNLOCK drops next cycle.
  - Keys 9,8,7,6 → 4 SHIFT_EN pulses, then a single REG_LOAD pulse two cycles after the last key is sampled, then IDLE.
  - PROG_REQ in IDLE has no effect.
- Reset mid-entry: after 2 keys, pulse RST low → DIGIT_CNT=0, state IDLE, no further pulses. The next 4 keys form a fresh entry.
- Success after failures: one failure (TRIES=1), then a match → TRIES=0 and UNLOCK asserted.

Source files
------------

// File: rtl/pass_seq_ctrl.sv
// Keypad password-lock sequencer: key edge acceptance, entry/check/open/programming
// flow, failed-attempt counting and alarm lockout. Every output comes straight from a flop.
module pass_seq_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 500,
    parameter int unsigned LOCK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] buttons_i,
    input  logic        prog_req_i,
    input  logic        equal_i,
    output logic        shift_en_o,
    output logic        reg_load_o,
    output logic        unlock_o,
    output logic        alarm_o,
    output logic        busy_o,
    output logic [3:0]  digit_cnt_o,
    output logic [3:0]  tries_o
);

    localparam int unsigned CNT_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // S_SETTLE lets the datapath absorb the final SHIFT_EN before EQUAL is sampled
    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_SETTLE, S_CHECK, S_OPEN, S_PROG_ENTRY, S_PROG_LOAD, S_LOCKOUT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] btn_prev_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]  digit_cnt_q, digit_cnt_d;
    logic [3:0]  tries_q, tries_d;
    logic        shift_en_q, shift_en_d;
    logic        reg_load_q, reg_load_d;
    logic        unlock_q, unlock_d;
    logic        alarm_q, alarm_d;
    logic        busy_q, busy_d;

    logic        onehot_c;
    logic        key_hit_c;
    logic        last_key_c;
    logic [3:0]  tries_inc_c;

    assign onehot_c    = (buttons_i != 16'd0) && ((buttons_i & (buttons_i - 16'd1)) == 16'd0);
    assign key_hit_c   = onehot_c && (btn_prev_q == 16'd0);
    assign last_key_c  = (digit_cnt_q == 4'(DIGITS - 1));
    assign tries_inc_c = tries_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        digit_cnt_d = digit_cnt_q;
        tries_d     = tries_q;
        shift_en_d  = 1'b0;
        reg_load_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_hit_c) begin
                    shift_en_d  = 1'b1;
                    digit_cnt_d = 4'd1;
                    state_d     = (DIGITS == 1) ? S_SETTLE : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (key_hit_c) begin
                    shift_en_d  = 1'b1;
                    digit_cnt_d = digit_cnt_q + 4'd1;
                    if (last_key_c) state_d = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_CHECK;
            S_CHECK: begin
                digit_cnt_d = 4'd0;
                if (equal_i) begin
                    tries_d = 4'd0;
                    timer_d = TW'(OPEN_CYCLES - 1);
                    state_d = S_OPEN;
                end else if (tries_inc_c >= 4'(MAX_TRIES)) begin
                    tries_d = 4'(MAX_TRIES);
                    timer_d = TW'(LOCK_CYCLES - 1);
                    state_d = S_LOCKOUT;
                end else begin
                    tries_d = tries_inc_c;
                    state_d = S_IDLE;
                end
            end
            S_OPEN: begin
                if (prog_req_i) begin
                    state_d = S_PROG_ENTRY;
                end else if (timer_q == TW'(0)) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_PROG_ENTRY: begin
                if (key_hit_c) begin
                    shift_en_d  = 1'b1;
                    digit_cnt_d = digit_cnt_q + 4'd1;
                    if (last_key_c) state_d = S_PROG_LOAD;
                end
            end
            S_PROG_LOAD: begin
                reg_load_d  = 1'b1;
                digit_cnt_d = 4'd0;
                state_d     = S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer_q == TW'(0)) begin
                    tries_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // status flags track the state being entered so they align with it
        unlock_d = (state_d == S_OPEN);
        alarm_d  = (state_d == S_LOCKOUT);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            btn_prev_q  <= 16'd0;
            timer_q     <= '0;
            digit_cnt_q <= 4'd0;
            tries_q     <= 4'd0;
            shift_en_q  <= 1'b0;
            reg_load_q  <= 1'b0;
            unlock_q    <= 1'b0;
            alarm_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= buttons_i;
            timer_q     <= timer_d;
            digit_cnt_q <= digit_cnt_d;
            tries_q     <= tries_d;
            shift_en_q  <= shift_en_d;
            reg_load_q  <= reg_load_d;
            unlock_q    <= unlock_d;
            alarm_q     <= alarm_d;
            busy_q      <= busy_d;
        end
    end

    assign shift_en_o  = shift_en_q;
    assign reg_load_o  = reg_load_q;
    assign unlock_o    = unlock_q;
    assign alarm_o     = alarm_q;
    assign busy_o      = busy_q;
    assign digit_cnt_o = digit_cnt_q;
    assign tries_o     = tries_q;

endmodule

// File: tb/tb_pass_seq_ctrl.sv
// Directed bench for pass_seq_ctrl with short open/lockout windows.
module tb_pass_seq_ctrl;

    localparam int unsigned OC = 10;
    localparam int unsigned LC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] buttons = 16'd0;
    logic        prog_req = 1'b0;
    logic        equal = 1'b0;
    logic        shift_en_o, reg_load_o, unlock_o, alarm_o, busy_o;
    logic [3:0]  digit_cnt_o, tries_o;

    int n_pass = 0;
    int n_total = 0;
    int sh_cnt = 0;
    int rl_cnt = 0;
    int ul_cnt = 0;
    int al_cnt = 0;

    pass_seq_ctrl #(
        .DIGITS(4), .MAX_TRIES(3), .OPEN_CYCLES(OC), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .buttons_i(buttons), .prog_req_i(prog_req),
        .equal_i(equal), .shift_en_o(shift_en_o), .reg_load_o(reg_load_o),
        .unlock_o(unlock_o), .alarm_o(alarm_o), .busy_o(busy_o),
        .digit_cnt_o(digit_cnt_o), .tries_o(tries_o)
    );

    always #5 clk = ~clk;

    // pulse/level cycle counters, sampled mid-cycle
    always @(negedge clk) begin
        if (shift_en_o) sh_cnt <= sh_cnt + 1;
        if (reg_load_o) rl_cnt <= rl_cnt + 1;
        if (unlock_o)   ul_cnt <= ul_cnt + 1;
        if (alarm_o)    al_cnt <= al_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        buttons = 16'h1 << k;
        cyc(1);
        buttons = 16'd0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        int s0, u0;
        cyc(2);
        n_total++; if (shift_en_o !== 1'b0) $display("FAIL rst_shift: got %b want 0", shift_en_o); else n_pass++;
        n_total++; if (reg_load_o !== 1'b0) $display("FAIL rst_load: got %b want 0", reg_load_o); else n_pass++;
        n_total++; if (unlock_o !== 1'b0) $display("FAIL rst_unlock: got %b want 0", unlock_o); else n_pass++;
        n_total++; if (alarm_o !== 1'b0) $display("FAIL rst_alarm: got %b want 0", alarm_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
        n_total++; if (digit_cnt_o !== 4'd0) $display("FAIL rst_digits: got %0d want 0", digit_cnt_o); else n_pass++;
        n_total++; if (tries_o !== 4'd0) $display("FAIL rst_tries: got %0d want 0", tries_o); else n_pass++;
        rst_n = 1'b1;
        cyc(1);
        equal = 1'b1;
        s0 = sh_cnt;
        u0 = ul_cnt;
        for (int i = 1; i <= 4; i++) begin
            press(i);
            n_total++;
            if (digit_cnt_o !== 4'(i)) $display("FAIL entry_digits: got %0d want %0d", digit_cnt_o, i); else n_pass++;
        end
        n_total++; if (sh_cnt - s0 !== 4) $display("FAIL entry_pulses: got %0d want 4", sh_cnt - s0); else n_pass++;
        n_total++; if (unlock_o !== 1'b0) $display("FAIL unlock_early: got %b want 0", unlock_o); else n_pass++;
        cyc(1);
        n_total++; if (unlock_o !== 1'b1) $display("FAIL unlock_rise: got %b want 1", unlock_o); else n_pass++;
        n_total++; if (busy_o !== 1'b1) $display("FAIL open_busy: got %b want 1", busy_o); else n_pass++;
        cyc(9);
        n_total++; if (unlock_o !== 1'b1) $display("FAIL unlock_last: got %b want 1", unlock_o); else n_pass++;
        cyc(1);
        n_total++; if (unlock_o !== 1'b0) $display("FAIL unlock_fall: got %b want 0", unlock_o); else n_pass++;
        cyc(3);
        n_total++; if (ul_cnt - u0 !== 10) $display("FAIL unlock_len: got %0d want 10", ul_cnt - u0); else n_pass++;
        n_total++; if (tries_o !== 4'd0) $display("FAIL open_tries: got %0d want 0", tries_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL open_idle: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_press_handling();
        int s0;
        equal = 1'b1;
        s0 = sh_cnt;
        buttons = 16'h1 << 5;
        cyc(8);
        buttons = 16'd0;
        cyc(1);
        n_total++; if (sh_cnt - s0 !== 1) $display("FAIL hold_pulses: got %0d want 1", sh_cnt - s0); else n_pass++;
        n_total++; if (digit_cnt_o !== 4'd1) $display("FAIL hold_digits: got %0d want 1", digit_cnt_o); else n_pass++;
        s0 = sh_cnt;
        buttons = 16'h0003;
        cyc(3);
        buttons = 16'd0;
        cyc(1);
        n_total++; if (sh_cnt - s0 !== 0) $display("FAIL multi_pulses: got %0d want 0", sh_cnt - s0); else n_pass++;
        n_total++; if (digit_cnt_o !== 4'd1) $display("FAIL multi_digits: got %0d want 1", digit_cnt_o); else n_pass++;
        press(1); press(2); press(3);
        cyc(1);
        n_total++; if (unlock_o !== 1'b1) $display("FAIL hold_open: got %b want 1", unlock_o); else n_pass++;
        s0 = sh_cnt;
        buttons = 16'h1 << 7;
        cyc(12);
        n_total++; if (busy_o !== 1'b0) $display("FAIL held_idle: got %b want 0", busy_o); else n_pass++;
        n_total++; if (sh_cnt - s0 !== 0) $display("FAIL held_across: got %0d want 0", sh_cnt - s0); else n_pass++;
        buttons = 16'd0;
        cyc(1);
        press(2);
        n_total++; if (sh_cnt - s0 !== 1) $display("FAIL after_release: got %0d want 1", sh_cnt - s0); else n_pass++;
        n_total++; if (digit_cnt_o !== 4'd1) $display("FAIL release_digits: got %0d want 1", digit_cnt_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_wrong_code();
        int s0, a0;
        equal = 1'b0;
        a0 = al_cnt;
        for (int t = 1; t <= 3; t++) begin
            press(1); press(2); press(3); press(4);
            cyc(1);
            n_total++;
            if (tries_o !== 4'(t)) $display("FAIL wrong_tries: got %0d want %0d", tries_o, t); else n_pass++;
            if (t < 3) begin
                n_total++;
                if (busy_o !== 1'b0 || alarm_o !== 1'b0)
                    $display("FAIL wrong_idle: got busy=%b alarm=%b want 0/0", busy_o, alarm_o);
                else n_pass++;
            end
        end
        n_total++; if (alarm_o !== 1'b1) $display("FAIL alarm_rise: got %b want 1", alarm_o); else n_pass++;
        s0 = sh_cnt;
        prog_req = 1'b1;
        press(1); press(2); press(3); press(4);
        prog_req = 1'b0;
        n_total++; if (sh_cnt - s0 !== 0) $display("FAIL lockout_keys: got %0d want 0", sh_cnt - s0); else n_pass++;
        n_total++; if (alarm_o !== 1'b1 || unlock_o !== 1'b0)
            $display("FAIL lockout_hold: got alarm=%b unlock=%b want 1/0", alarm_o, unlock_o); else n_pass++;
        cyc(15);
        n_total++; if (al_cnt - a0 !== 20) $display("FAIL alarm_len: got %0d want 20", al_cnt - a0); else n_pass++;
        n_total++; if (tries_o !== 4'd0) $display("FAIL lockout_tries: got %0d want 0", tries_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL lockout_idle: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_programming();
        int s0, r0;
        equal = 1'b1;
        press(1); press(2); press(3); press(4);
        cyc(3);
        prog_req = 1'b1;
        cyc(1);
        prog_req = 1'b0;
        n_total++; if (unlock_o !== 1'b0) $display("FAIL prog_unlock: got %b want 0", unlock_o); else n_pass++;
        n_total++; if (busy_o !== 1'b1) $display("FAIL prog_busy: got %b want 1", busy_o); else n_pass++;
        s0 = sh_cnt;
        r0 = rl_cnt;
        press(9); press(8); press(7);
        n_total++; if (digit_cnt_o !== 4'd3) $display("FAIL prog_digits: got %0d want 3", digit_cnt_o); else n_pass++;
        buttons = 16'h1 << 6;
        cyc(1);
        buttons = 16'd0;
        n_total++; if (shift_en_o !== 1'b1 || reg_load_o !== 1'b0)
            $display("FAIL prog_last: got shift=%b load=%b want 1/0", shift_en_o, reg_load_o); else n_pass++;
        cyc(1);
        n_total++; if (reg_load_o !== 1'b1 || shift_en_o !== 1'b0)
            $display("FAIL prog_load: got load=%b shift=%b want 1/0", reg_load_o, shift_en_o); else n_pass++;
        cyc(1);
        n_total++; if (reg_load_o !== 1'b0) $display("FAIL load_width: got %b want 0", reg_load_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0 || digit_cnt_o !== 4'd0)
            $display("FAIL prog_done: got busy=%b digits=%0d want 0/0", busy_o, digit_cnt_o); else n_pass++;
        n_total++; if (sh_cnt - s0 !== 4) $display("FAIL prog_pulses: got %0d want 4", sh_cnt - s0); else n_pass++;
        n_total++; if (rl_cnt - r0 !== 1) $display("FAIL prog_loads: got %0d want 1", rl_cnt - r0); else n_pass++;
        prog_req = 1'b1;
        cyc(3);
        prog_req = 1'b0;
        n_total++; if (busy_o !== 1'b0) $display("FAIL idle_prog: got %b want 0", busy_o); else n_pass++;
        n_total++; if (rl_cnt - r0 !== 1) $display("FAIL idle_prog_load: got %0d want 1", rl_cnt - r0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s0;
        equal = 1'b1;
        press(1); press(2);
        n_total++; if (digit_cnt_o !== 4'd2) $display("FAIL mid_digits: got %0d want 2", digit_cnt_o); else n_pass++;
        s0 = sh_cnt;
        rst_n = 1'b0;
        #3;
        n_total++; if (digit_cnt_o !== 4'd0 || busy_o !== 1'b0)
            $display("FAIL mid_reset: got digits=%0d busy=%b want 0/0", digit_cnt_o, busy_o); else n_pass++;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        n_total++; if (sh_cnt - s0 !== 0) $display("FAIL mid_pulses: got %0d want 0", sh_cnt - s0); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            press(i + 10);
            n_total++;
            if (digit_cnt_o !== 4'(i)) $display("FAIL fresh_digits: got %0d want %0d", digit_cnt_o, i); else n_pass++;
        end
        cyc(1);
        n_total++; if (unlock_o !== 1'b1) $display("FAIL fresh_unlock: got %b want 1", unlock_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_recover();
        equal = 1'b0;
        press(1); press(2); press(3); press(4);
        cyc(1);
        n_total++; if (tries_o !== 4'd1) $display("FAIL recover_fail: got %0d want 1", tries_o); else n_pass++;
        equal = 1'b1;
        press(1); press(2); press(3); press(4);
        cyc(1);
        n_total++; if (tries_o !== 4'd0) $display("FAIL recover_tries: got %0d want 0", tries_o); else n_pass++;
        n_total++; if (unlock_o !== 1'b1) $display("FAIL recover_unlock: got %b want 1", unlock_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_press_handling();
        test_wrong_code();
        test_programming();
        test_reset_mid();
        test_recover();
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
